mem_port_arbiter: RTL

- Shares the single external memory port between the instruction-cache refill path and the data-cache path (line refill reads, write-through stores).
- Sits between the two caches and the memory bus. The core's control FSM only ever sees icache_ready/dcache_ready, which the caches derive from this block's done pulses.
- Fixed priority to the data cache, with a starvation limit that guarantees instruction-fetch progress.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between icache refills and dcache reads/writes.
// The data cache has fixed priority; a starvation counter forces an icache grant after STARVE_LIMIT dcache wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int IC_BURST     = 4,
  parameter int DC_BURST     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_cmd_we,
  output logic [3:0]        mem_cmd_len,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_bvalid
);

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_CMD   = 4'b0010;
  localparam logic [3:0] S_RDATA = 4'b0100;
  localparam logic [3:0] S_WRESP = 4'b1000;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IC   = 2'b01;
  localparam logic [1:0] OWN_DC   = 2'b10;

  localparam logic [3:0] IC_LEN = 4'(IC_BURST - 1);
  localparam logic [3:0] DC_LEN = 4'(DC_BURST - 1);

  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [3:0]        state_q,  state_d;
  logic [1:0]        owner_q,  owner_d;
  logic [3:0]        beat_q,   beat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              we_q,     we_d;
  logic [3:0]        len_q,    len_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;

  logic rd_beat;
  logic last_beat;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    len_d    = len_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        owner_d = OWN_NONE;
        if (!ic_req) starve_d = '0;
        if (ic_req && (!dc_req || starve_q >= STARVE_MAX)) begin
          owner_d  = OWN_IC;
          addr_d   = ic_addr;
          we_d     = 1'b0;
          len_d    = IC_LEN;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = S_CMD;
        end else if (dc_req) begin
          owner_d = OWN_DC;
          addr_d  = dc_addr;
          we_d    = dc_we;
          len_d   = dc_we ? 4'd0 : DC_LEN;
          wdata_d = dc_wdata;
          if (ic_req) starve_d = starve_q + 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_cmd_ready) begin
          beat_d  = '0;
          state_d = we_q ? S_WRESP : S_RDATA;
        end
      end
      S_RDATA: begin
        if (mem_rvalid) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == len_q) begin
            owner_d = OWN_NONE;
            state_d = S_IDLE;
          end
        end
      end
      S_WRESP: begin
        if (mem_bvalid) begin
          owner_d = OWN_NONE;
          state_d = S_IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      beat_q   <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      len_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
    end
  end

  // Read beats bypass the registers so the owner sees data and done in the beat's own cycle.
  assign rd_beat   = (state_q == S_RDATA) && mem_rvalid;
  assign last_beat = rd_beat && (beat_q == len_q);

  assign ic_rvalid = rd_beat && (owner_q == OWN_IC);
  assign ic_done   = last_beat && (owner_q == OWN_IC);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;

  assign dc_rvalid = rd_beat && (owner_q == OWN_DC);
  assign dc_done   = (last_beat && (owner_q == OWN_DC)) || ((state_q == S_WRESP) && mem_bvalid);
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

  assign mem_cmd_valid = (state_q == S_CMD);
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_we    = we_q;
  assign mem_cmd_len   = len_q;
  assign mem_cmd_wdata = wdata_q;

endmodule
